// File: rtl/seg_scan_mux.sv
// Six-digit 7-segment scan multiplexer. It snapshots all six patterns once per
// frame and blanks the display at the start of each digit slot.
module seg_scan_mux #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [6:0] an0,
  input  logic [6:0] an1,
  input  logic [6:0] an2,
  input  logic [6:0] an3,
  input  logic [6:0] an4,
  input  logic [6:0] an5,
  output logic [6:0] seg_out,
  output logic [5:0] dig_en,
  output logic       frame_tick
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [6:0]       frame_buf [6];

  logic             frame_start;
  logic             blanking;
  logic [6:0]       seg_sel;
  logic [5:0]       dig_sel;

  assign frame_start = (cnt == '0) && (idx == 3'd0);
  assign blanking    = (cnt < CNT_BLANK);

  always_comb begin
    seg_sel = 7'h7F;
    dig_sel = 6'h3F;
    case (idx)
      3'd0: begin seg_sel = frame_buf[0]; dig_sel = 6'h3E; end
      3'd1: begin seg_sel = frame_buf[1]; dig_sel = 6'h3D; end
      3'd2: begin seg_sel = frame_buf[2]; dig_sel = 6'h3B; end
      3'd3: begin seg_sel = frame_buf[3]; dig_sel = 6'h37; end
      3'd4: begin seg_sel = frame_buf[4]; dig_sel = 6'h2F; end
      3'd5: begin seg_sel = frame_buf[5]; dig_sel = 6'h1F; end
      default: begin seg_sel = 7'h7F; dig_sel = 6'h3F; end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      idx        <= 3'd0;
      for (int k = 0; k < 6; k++) frame_buf[k] <= 7'h7F;
      seg_out    <= 7'h7F;
      dig_en     <= 6'h3F;
      frame_tick <= 1'b0;
    end else if (en) begin
      // The snapshot lands inside blanking, so it never disturbs a lit digit.
      if (frame_start) begin
        frame_buf[0] <= an0;
        frame_buf[1] <= an1;
        frame_buf[2] <= an2;
        frame_buf[3] <= an3;
        frame_buf[4] <= an4;
        frame_buf[5] <= an5;
      end
      frame_tick <= frame_start;
      seg_out    <= blanking ? 7'h7F : seg_sel;
      dig_en     <= blanking ? 6'h3F : dig_sel;
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      seg_out    <= 7'h7F;
      dig_en     <= 6'h3F;
      frame_tick <= 1'b0;
    end
  end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Downstream display driver for the digital clock top level. It consumes the six 7-segment patterns an0..an5 (seconds, minutes and hours digits; active-low segments, 1 = segment off).
- It time-multiplexes them onto a single shared segment bus with one-hot active-low digit enables, so the board needs 7+6 pins instead of 42.
- It snapshots all six patterns once per frame, so a digit change never tears mid-frame.
- It inserts a blanking interval at the start of each digit slot to suppress ghosting.

Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot (1 kHz per digit at 50 MHz); must be >= BLANK_CYC+2.
- BLANK_CYC, 16, dead-time cycles at the start of each slot (digits off); must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  scan enable; low freezes the scan and blanks the display.
- an0  input  7  seconds-ones segment pattern, active-low.
- an1  input  7  seconds-tens segment pattern, active-low.
- an2  input  7  minutes-ones segment pattern, active-low.
- an3  input  7  minutes-tens segment pattern, active-low.
- an4  input  7  hours-ones segment pattern, active-low.
- an5  input  7  hours-tens segment pattern, active-low.
- seg_out  output  7  shared segment bus, active-low, registered.
- dig_en  output  6  digit enables, active-low one-hot, registered; bit k drives anode of digit k.
- frame_tick  output  1  one-cycle pulse, registered, marking the start of each frame.

Behaviour:

State:
- Slot counter cnt, width clog2(SCAN_DIV), range 0..SCAN_DIV-1.
- Digit index idx, 3 bits, range 0..5.
- Frame buffer buf[0..5], 7 bits each.

Reset (reset low, asynchronous):
- cnt=0, idx=0, all buf entries = 7'h7F.
- seg_out=7'h7F, dig_en=6'h3F, frame_tick=0.
- Release is synchronous to the next clk edge. Asserting reset mid-slot or mid-frame aborts immediately; the scan restarts from digit 0 with cnt=0.

Counting (en=1):
- cnt increments each cycle.
- At cnt==SCAN_DIV-1: cnt becomes 0 and idx advances. Wrap 5 -> 0 only; idx never takes values 6 or 7.

Snapshot:
- On the edge where en=1, cnt==0 and idx==0, buf[k] <= an_k for all k simultaneously.
- Input changes at any other time have no effect until the next frame start.

Output registration (one-cycle latency):
- Outputs at edge n+1 are computed from the state (cnt, idx, buf) present during cycle n.
- If cnt < BLANK_CYC: seg_out=7'h7F, dig_en=6'h3F.
- Otherwise: seg_out=buf[idx], dig_en = all ones except bit idx = 0.
- frame_tick = 1 exactly when state was cnt==0 and idx==0 with en=1; otherwise 0.
- Consequence: each digit is lit for SCAN_DIV-BLANK_CYC cycles per slot. Frame period is 6*SCAN_DIV cycles. At most one dig_en bit is low at any time.

en=0:
- cnt, idx and buf hold.
- Next edge: seg_out=7'h7F, dig_en=6'h3F, frame_tick=0.
- When en returns high, scanning resumes from the held cnt/idx with no extra snapshot. A snapshot occurs only if the held state is cnt==0, idx==0.

Simultaneous events: a snapshot and the buf[0] display never conflict. The snapshot happens at cnt==0, which is inside blanking.

Test Plan (SCAN_DIV=8, BLANK_CYC=2):
1. Hold reset low, then release with en=1 and an0..an5 = 7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12.
   - During reset: seg_out=7'h7F, dig_en=6'h3F, frame_tick=0.
   - First edge after release: frame_tick=1.
   - Edges 3..8: dig_en=6'h3E, seg_out=7'h40.
   - Edges 9..10: blank.
   - Edges 11..16: dig_en=6'h3D, seg_out=7'h79.
2. Run 2 frames (96 cycles).
   - Each dig_en value 3E, 3D, 3B, 37, 2F, 1F appears for 6 consecutive cycles, followed by 2 blank cycles, in order.
   - frame_tick pulses exactly every 48 cycles.
   - dig_en never has more than one 0 bit.
3. Change an0 to 7'h79 in the middle of digit 2's slot.
   - Digit 0 shows 7'h40 for the rest of the current frame.
   - Digit 0 shows 7'h79 starting in the next frame, after the frame_tick.
4. Drop en low for 10 cycles during digit 3's lit window.
   - Next edge: seg_out=7'h7F, dig_en=6'h3F, no frame_tick.
   - After en returns high, digit 3 resumes and completes the remaining lit cycles of its slot. Total lit cycles for that slot = 6.
5. Assert reset low asynchronously (between edges) while digit 4 is lit.
   - Outputs go blank immediately, with no clk edge needed.
   - After release, the sequence restarts exactly as in scenario 1.
